decode_issue: RTL and testbench
===============================

// Module: decode_issue
// PURPOSE
//  Producer side of the execute-stage operand interface: accepts fetched instruction words, decodes them into
//  opecode/immf/cc/imm_ex, reads rd/rs from the register file with writeback bypass, and presents one operand
//  bundle per transfer to execute. Two-entry skid buffer so in_ready is a register output.
//  Sits between fetch and execute; field widths and opcode encodings come from defs_insn.v.
// PARAMETERS (from defs_insn.v)
//  LEN_INSN 32 instruction word width | LEN_REG 32 data width | LEN_OPECODE 6 | LEN_IMMF 1 | LEN_CC 4
//  LEN_REGADDR 5 register index width | LEN_IMM 16 raw immediate | LEN_IMM_EX 32 extended immediate
//  Field layout: opecode=[31:26] immf=[25] cc=[24:21] rd=[20:16] rs=[15:11] imm=[15:0] (imm overlays rs)
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous reset, active-high
//  in_valid    in   1             fetch has an instruction
//  in_ready    out  1             decode_issue can take one (registered)
//  in_insn     in   LEN_INSN      instruction word
//  rf_raddr_rd out  LEN_REGADDR   regfile read address A (comb. from in_insn)
//  rf_raddr_rs out  LEN_REGADDR   regfile read address B
//  rf_rdata_rd in   LEN_REG       regfile data A (asynchronous read)
//  rf_rdata_rs in   LEN_REG       regfile data B
//  wb_we       in   1             writeback this cycle
//  wb_addr     in   LEN_REGADDR   writeback register
//  wb_data     in   LEN_REG       writeback data
//  out_valid   out  1             bundle valid toward execute
//  out_ready   in   1             execute accepts
//  opecode     out  LEN_OPECODE   to execute
//  immf        out  LEN_IMMF      1: use imm_ex in place of data_rs
//  cc          out  LEN_CC        condition code field
//  data_rd     out  LEN_REG       operand rd
//  data_rs     out  LEN_REG       operand rs (0 when immf=1)
//  imm_ex      out  LEN_IMM_EX    sign-extended imm
//  illegal     out  1             sticky: undefined opecode was accepted
// BEHAVIOUR
//  - Reset (async): both buffer entries invalid, in_ready=1, out_valid=0, all data outputs 0, illegal=0.
//  - Transfer on in_valid&in_ready (input) and out_valid&out_ready (output); a transfer occurs only then.
//  - Decode + regfile read + bypass happen in the accepting cycle; the decoded bundle is registered.
//    Latency: insn accepted at edge N is on outputs after edge N, out_valid=1 in cycle N+1 if buffer was empty.
//  - Bypass: if wb_we & wb_addr==rd (resp. rs) in the accepting cycle, wb_data replaces rf_rdata. Register 0 reads
//    as 0 regardless of regfile or bypass. Bundles already buffered are not re-bypassed (writeback ordering is
//    upstream's responsibility).
//  - imm_ex = {{16{imm[15]}},imm} always; data_rs forced to 0 when immf=1.
//  - Skid buffer states: EMPTY (in_ready=1,out_valid=0), ONE (1,1), FULL (0,1). Main reg drives outputs, skid reg
//    holds overflow. EMPTY-accept->ONE; ONE-accept-no-drain->FULL; ONE-drain-no-accept->EMPTY; ONE-both->ONE
//    (new bundle to main); FULL-drain->ONE (skid moves to main); FULL never accepts.
//  - Outputs held stable while out_valid&!out_ready. Order preserved (FIFO).
//  - illegal set when an accepted opecode is not in the defined set; cleared only by rst; bundle still issued.
//  - Reset mid-operation discards both entries; no partial bundle appears after release.
// STRUCTURE
//  - defs_insn.v holds LEN_* widths, field bit positions, OPECODE_* values; no new constants outside it.
//  - Sub-module insn_field_decode (combinational: insn -> opecode/immf/cc/rd/rs/imm_ex/illegal); top owns
//    bypass, skid-buffer state and output registers.
// TESTING
//  1 Reset then ADD, immf=0, rd=1 (rf=32'h1234_0000), rs=2 (rf=32'h0000_5678), out_ready=1 -> next cycle
//    out_valid=1, opecode=OPECODE_ADD, data_rd=32'h1234_0000, data_rs=32'h0000_5678.
//  2 SHL immf=1 imm=16'h0008, rd=3 (rf=32'h0000_1234) -> data_rd=32'h0000_1234, imm_ex=32'h0000_0008, data_rs=0;
//    imm=16'hFFF8 -> imm_ex=32'hFFFF_FFF8.
//  3 Bypass: accept rd=5 while wb_we=1 wb_addr=5 wb_data=32'hDEAD_BEEF, rf=0 -> data_rd=32'hDEAD_BEEF;
//    rd=0 with same writeback to addr 0 -> data_rd=0.
//  4 Backpressure: out_ready=0, stream 3 insns -> 2 accepted, in_ready=0 after 2nd, outputs frozen on insn1;
//    raise out_ready -> insns 1,2,3 emerge in order, none lost or duplicated.
//  5 Undefined opecode accepted -> illegal=1 and stays 1 through following ADDs until rst.
//  6 Assert rst while FULL -> in_ready=1, out_valid=0 immediately; first post-reset insn emerges first.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - instruction field widths, positions, opecode values and shared types
//
// Purpose: single home for the instruction-format constants used by decode_issue
//   and its field decoder, plus the operand bundle type and skid-buffer state type.
// Ports: none (package).
package decode_issue_pkg;

  localparam int LEN_INSN    = 32;
  localparam int LEN_REG     = 32;
  localparam int LEN_OPECODE = 6;
  localparam int LEN_IMMF    = 1;
  localparam int LEN_CC      = 4;
  localparam int LEN_REGADDR = 5;
  localparam int LEN_IMM     = 16;
  localparam int LEN_IMM_EX  = 32;

  // Field LSB positions; imm overlays rs in the low half of the word.
  localparam int POS_OPECODE = 26;
  localparam int POS_IMMF    = 25;
  localparam int POS_CC      = 21;
  localparam int POS_RD      = 16;
  localparam int POS_RS      = 11;
  localparam int POS_IMM     = 0;

  localparam logic [LEN_OPECODE-1:0] OPECODE_ADD = 6'h00;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SUB = 6'h01;
  localparam logic [LEN_OPECODE-1:0] OPECODE_AND = 6'h02;
  localparam logic [LEN_OPECODE-1:0] OPECODE_OR  = 6'h03;
  localparam logic [LEN_OPECODE-1:0] OPECODE_XOR = 6'h04;
  localparam logic [LEN_OPECODE-1:0] OPECODE_NOT = 6'h05;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SHL = 6'h06;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SHR = 6'h07;
  localparam logic [LEN_OPECODE-1:0] OPECODE_SRA = 6'h08;
  localparam logic [LEN_OPECODE-1:0] OPECODE_MUL = 6'h09;
  localparam logic [LEN_OPECODE-1:0] OPECODE_LD  = 6'h10;
  localparam logic [LEN_OPECODE-1:0] OPECODE_ST  = 6'h11;
  localparam logic [LEN_OPECODE-1:0] OPECODE_B   = 6'h14;
  localparam logic [LEN_OPECODE-1:0] OPECODE_BL  = 6'h15;
  localparam logic [LEN_OPECODE-1:0] OPECODE_JR  = 6'h16;
  localparam logic [LEN_OPECODE-1:0] OPECODE_NOP = 6'h3E;

  function automatic logic is_defined_opecode(input logic [LEN_OPECODE-1:0] op);
    case (op)
      OPECODE_ADD, OPECODE_SUB, OPECODE_AND, OPECODE_OR, OPECODE_XOR,
      OPECODE_NOT, OPECODE_SHL, OPECODE_SHR, OPECODE_SRA, OPECODE_MUL,
      OPECODE_LD, OPECODE_ST, OPECODE_B, OPECODE_BL, OPECODE_JR,
      OPECODE_NOP: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  typedef struct packed {
    logic [LEN_OPECODE-1:0] opecode;
    logic [LEN_IMMF-1:0]    immf;
    logic [LEN_CC-1:0]      cc;
    logic [LEN_REG-1:0]     data_rd;
    logic [LEN_REG-1:0]     data_rs;
    logic [LEN_IMM_EX-1:0]  imm_ex;
  } bundle_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/decode_issue_insn_field_decode.sv
// rtl/decode_issue_insn_field_decode.sv - combinational instruction field splitter
//
// Purpose: slice an instruction word into its fields and flag undefined opecodes.
// Ports:
//   insn    in   LEN_INSN     instruction word
//   opecode out  LEN_OPECODE  [31:26]
//   immf    out  LEN_IMMF     [25]
//   cc      out  LEN_CC       [24:21]
//   rd      out  LEN_REGADDR  [20:16]
//   rs      out  LEN_REGADDR  [15:11]
//   imm_ex  out  LEN_IMM_EX   sign-extended [15:0]
//   illegal out  1            opecode outside the defined set
module insn_field_decode
  import decode_issue_pkg::*;
(
  input  logic [LEN_INSN-1:0]    insn,
  output logic [LEN_OPECODE-1:0] opecode,
  output logic [LEN_IMMF-1:0]    immf,
  output logic [LEN_CC-1:0]      cc,
  output logic [LEN_REGADDR-1:0] rd,
  output logic [LEN_REGADDR-1:0] rs,
  output logic [LEN_IMM_EX-1:0]  imm_ex,
  output logic                   illegal
);

  logic [LEN_IMM-1:0] imm;

  assign opecode = insn[POS_OPECODE +: LEN_OPECODE];
  assign immf    = insn[POS_IMMF    +: LEN_IMMF];
  assign cc      = insn[POS_CC      +: LEN_CC];
  assign rd      = insn[POS_RD      +: LEN_REGADDR];
  assign rs      = insn[POS_RS      +: LEN_REGADDR];
  assign imm     = insn[POS_IMM     +: LEN_IMM];

  assign imm_ex  = {{(LEN_IMM_EX-LEN_IMM){imm[LEN_IMM-1]}}, imm};
  assign illegal = ~is_defined_opecode(opecode);

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - decode, operand read with writeback bypass, two-entry skid buffer to execute
//
// Purpose: accept instruction words from fetch, decode them, read rd/rs from the
//   register file (bypassing a same-cycle writeback) and hand one operand bundle
//   per transfer to execute. in_ready and all bundle outputs are registers.
// Ports:
//   clk, rst                    clock (rising), async active-high reset
//   in_valid/in_ready/in_insn   instruction input handshake
//   rf_raddr_rd/rf_raddr_rs     regfile read addresses (combinational from in_insn)
//   rf_rdata_rd/rf_rdata_rs     regfile read data (asynchronous read)
//   wb_we/wb_addr/wb_data       writeback port, used for bypass
//   out_valid/out_ready         bundle output handshake
//   opecode/immf/cc/data_rd/data_rs/imm_ex  operand bundle
//   illegal                     sticky: an undefined opecode was accepted
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN_INSN-1:0]    in_insn,
  output logic [LEN_REGADDR-1:0] rf_raddr_rd,
  output logic [LEN_REGADDR-1:0] rf_raddr_rs,
  input  logic [LEN_REG-1:0]     rf_rdata_rd,
  input  logic [LEN_REG-1:0]     rf_rdata_rs,
  input  logic                   wb_we,
  input  logic [LEN_REGADDR-1:0] wb_addr,
  input  logic [LEN_REG-1:0]     wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_OPECODE-1:0] opecode,
  output logic [LEN_IMMF-1:0]    immf,
  output logic [LEN_CC-1:0]      cc,
  output logic [LEN_REG-1:0]     data_rd,
  output logic [LEN_REG-1:0]     data_rs,
  output logic [LEN_IMM_EX-1:0]  imm_ex,
  output logic                   illegal
);

  logic [LEN_OPECODE-1:0] dec_opecode;
  logic [LEN_IMMF-1:0]    dec_immf;
  logic [LEN_CC-1:0]      dec_cc;
  logic [LEN_REGADDR-1:0] dec_rd;
  logic [LEN_REGADDR-1:0] dec_rs;
  logic [LEN_IMM_EX-1:0]  dec_imm_ex;
  logic                   dec_illegal;

  insn_field_decode u_field_decode (
    .insn    (in_insn),
    .opecode (dec_opecode),
    .immf    (dec_immf),
    .cc      (dec_cc),
    .rd      (dec_rd),
    .rs      (dec_rs),
    .imm_ex  (dec_imm_ex),
    .illegal (dec_illegal)
  );

  assign rf_raddr_rd = dec_rd;
  assign rf_raddr_rs = dec_rs;

  // Operand selection for the word being accepted this cycle. r0 is hardwired
  // zero, so it wins over both the regfile and the bypass.
  logic [LEN_REG-1:0] opnd_rd;
  logic [LEN_REG-1:0] opnd_rs;
  bundle_t            new_bundle;

  always_comb begin
    opnd_rd = rf_rdata_rd;
    if (wb_we && (wb_addr == dec_rd)) opnd_rd = wb_data;
    if (dec_rd == '0)                 opnd_rd = '0;

    opnd_rs = rf_rdata_rs;
    if (wb_we && (wb_addr == dec_rs)) opnd_rs = wb_data;
    if (dec_rs == '0)                 opnd_rs = '0;
    // With immf set the rs field is really immediate bits; don't leak a register.
    if (dec_immf != '0)               opnd_rs = '0;

    new_bundle         = '0;
    new_bundle.opecode = dec_opecode;
    new_bundle.immf    = dec_immf;
    new_bundle.cc      = dec_cc;
    new_bundle.data_rd = opnd_rd;
    new_bundle.data_rs = opnd_rs;
    new_bundle.imm_ex  = dec_imm_ex;
  end

  skid_state_t state;
  bundle_t     main_q;
  bundle_t     skid_q;
  logic        accept;
  logic        drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // main_q always drives the outputs; skid_q only catches the one bundle that
  // arrives while main_q is stalled, which is what lets in_ready be registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SKID_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (accept && dec_illegal) illegal <= 1'b1;

      case (state)
        SKID_EMPTY: begin
          if (accept) begin
            main_q    <= new_bundle;
            out_valid <= 1'b1;
            state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            main_q <= new_bundle;
          end else if (accept) begin
            skid_q   <= new_bundle;
            in_ready <= 1'b0;
            state    <= SKID_FULL;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= SKID_EMPTY;
        end
      endcase
    end
  end

  assign opecode = main_q.opecode;
  assign immf    = main_q.immf;
  assign cc      = main_q.cc;
  assign data_rd = main_q.data_rd;
  assign data_rs = main_q.data_rs;
  assign imm_ex  = main_q.imm_ex;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed self-checking bench for decode_issue
module tb_decode_issue;
  import decode_issue_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LEN_INSN-1:0]    in_insn;
  logic [LEN_REGADDR-1:0] rf_raddr_rd;
  logic [LEN_REGADDR-1:0] rf_raddr_rs;
  logic [LEN_REG-1:0]     rf_rdata_rd;
  logic [LEN_REG-1:0]     rf_rdata_rs;
  logic                   wb_we;
  logic [LEN_REGADDR-1:0] wb_addr;
  logic [LEN_REG-1:0]     wb_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LEN_OPECODE-1:0] opecode;
  logic [LEN_IMMF-1:0]    immf;
  logic [LEN_CC-1:0]      cc;
  logic [LEN_REG-1:0]     data_rd;
  logic [LEN_REG-1:0]     data_rs;
  logic [LEN_IMM_EX-1:0]  imm_ex;
  logic                   illegal;

  logic [LEN_REG-1:0] rf [32];
  int total;
  int bad;

  assign rf_rdata_rd = rf[rf_raddr_rd];
  assign rf_rdata_rs = rf[rf_raddr_rs];

  decode_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_insn     (in_insn),
    .rf_raddr_rd (rf_raddr_rd),
    .rf_raddr_rs (rf_raddr_rs),
    .rf_rdata_rd (rf_rdata_rd),
    .rf_rdata_rs (rf_rdata_rs),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opecode     (opecode),
    .immf        (immf),
    .cc          (cc),
    .data_rd     (data_rd),
    .data_rs     (data_rs),
    .imm_ex      (imm_ex),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic f, input logic [3:0] c,
                                      input logic [4:0] rd, input logic [15:0] low);
    return {op, f, c, rd, low};
  endfunction

  function automatic logic [15:0] rs_low(input logic [4:0] rs);
    return {rs, 11'h000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (data_rd !== 32'h0) begin bad++; $display("FAIL reset_data_rd got=%h exp=0", data_rd); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    rf[1] = 32'h1234_0000;
    rf[2] = 32'h0000_5678;
    out_ready = 1'b1;
    in_insn   = mk(OPECODE_ADD, 1'b0, 4'h5, 5'd1, rs_low(5'd2));
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    total++; if (opecode !== OPECODE_ADD) begin bad++; $display("FAIL add_opecode got=%h exp=%h", opecode, OPECODE_ADD); end
    total++; if (cc !== 4'h5) begin bad++; $display("FAIL add_cc got=%h exp=5", cc); end
    total++; if (data_rd !== 32'h1234_0000) begin bad++; $display("FAIL add_data_rd got=%h exp=12340000", data_rd); end
    total++; if (data_rs !== 32'h0000_5678) begin bad++; $display("FAIL add_data_rs got=%h exp=00005678", data_rs); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_imm();
    rf[3]  = 32'h0000_1234;
    rf[31] = 32'hAAAA_5555;
    out_ready = 1'b1;
    in_insn   = mk(OPECODE_SHL, 1'b1, 4'h0, 5'd3, 16'h0008);
    in_valid  = 1'b1;
    step();
    in_insn = mk(OPECODE_SHL, 1'b1, 4'h0, 5'd3, 16'hFFF8);
    total++; if (data_rd !== 32'h0000_1234) begin bad++; $display("FAIL imm_data_rd got=%h exp=00001234", data_rd); end
    total++; if (imm_ex !== 32'h0000_0008) begin bad++; $display("FAIL imm_pos got=%h exp=00000008", imm_ex); end
    total++; if (immf !== 1'b1) begin bad++; $display("FAIL imm_immf got=%b exp=1", immf); end
    total++; if (data_rs !== 32'h0) begin bad++; $display("FAIL imm_data_rs got=%h exp=0", data_rs); end
    step();
    in_valid = 1'b0;
    total++; if (imm_ex !== 32'hFFFF_FFF8) begin bad++; $display("FAIL imm_neg got=%h exp=fffffff8", imm_ex); end
    total++; if (data_rs !== 32'h0) begin bad++; $display("FAIL imm_neg_data_rs got=%h exp=0", data_rs); end
    drain_idle();
  endtask

  task automatic test_bypass();
    rf[5] = 32'h0;
    rf[6] = 32'h0000_0066;
    rf[0] = 32'h0000_1111;
    rf[7] = 32'h0000_0077;
    out_ready = 1'b1;
    wb_we   = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'hDEAD_BEEF;
    in_insn  = mk(OPECODE_ADD, 1'b0, 4'h0, 5'd5, rs_low(5'd6));
    in_valid = 1'b1;
    step();
    total++; if (data_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rd got=%h exp=deadbeef", data_rd); end
    total++; if (data_rs !== 32'h0000_0066) begin bad++; $display("FAIL byp_rs_nohit got=%h exp=00000066", data_rs); end
    in_insn = mk(OPECODE_ADD, 1'b0, 4'h0, 5'd7, rs_low(5'd5));
    step();
    total++; if (data_rs !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rs got=%h exp=deadbeef", data_rs); end
    total++; if (data_rd !== 32'h0000_0077) begin bad++; $display("FAIL byp_rd_nohit got=%h exp=00000077", data_rd); end
    wb_addr = 5'd0;
    in_insn = mk(OPECODE_ADD, 1'b0, 4'h0, 5'd0, rs_low(5'd6));
    step();
    in_valid = 1'b0;
    wb_we    = 1'b0;
    total++; if (data_rd !== 32'h0) begin bad++; $display("FAIL byp_r0 got=%h exp=0", data_rd); end
    drain_idle();
  endtask

  task automatic test_back_to_back();
    rf[8]  = 32'h0000_0800;
    rf[10] = 32'h0000_0A00;
    rf[11] = 32'h0000_0B00;
    out_ready = 1'b0;
    in_insn  = mk(OPECODE_ADD, 1'b0, 4'h0, 5'd8, rs_low(5'd0));
    in_valid = 1'b1;
    step();
    in_insn = mk(OPECODE_SUB, 1'b0, 4'h0, 5'd10, rs_low(5'd0));
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    total++; if (data_rd !== 32'h0000_0800) begin bad++; $display("FAIL bp_hold1 got=%h exp=00000800", data_rd); end
    in_insn = mk(OPECODE_AND, 1'b0, 4'h0, 5'd11, rs_low(5'd0));
    step();
    step();
    total++; if (data_rd !== 32'h0000_0800) begin bad++; $display("FAIL bp_frozen got=%h exp=00000800", data_rd); end
    total++; if (opecode !== OPECODE_ADD) begin bad++; $display("FAIL bp_frozen_op got=%h exp=%h", opecode, OPECODE_ADD); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (data_rd !== 32'h0000_0A00) begin bad++; $display("FAIL bp_second got=%h exp=00000a00", data_rd); end
    total++; if (opecode !== OPECODE_SUB) begin bad++; $display("FAIL bp_second_op got=%h exp=%h", opecode, OPECODE_SUB); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (data_rd !== 32'h0000_0B00) begin bad++; $display("FAIL bp_third got=%h exp=00000b00", data_rd); end
    total++; if (opecode !== OPECODE_AND) begin bad++; $display("FAIL bp_third_op got=%h exp=%h", opecode, OPECODE_AND); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_before got=%b exp=0", illegal); end
    in_insn  = mk(6'h3F, 1'b0, 4'h0, 5'd1, rs_low(5'd2));
    in_valid = 1'b1;
    step();
    in_insn = mk(OPECODE_ADD, 1'b0, 4'h0, 5'd1, rs_low(5'd2));
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_set got=%b exp=1", illegal); end
    total++; if (out_valid !== 1'b1 || opecode !== 6'h3F) begin bad++; $display("FAIL ill_issued got=%b/%h exp=1/3f", out_valid, opecode); end
    step();
    step();
    in_valid = 1'b0;
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", illegal); end
    drain_idle();
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_sticky_idle got=%b exp=1", illegal); end
  endtask

  task automatic test_reset_full();
    rf[12] = 32'h0000_0C0C;
    out_ready = 1'b0;
    in_insn  = mk(OPECODE_OR, 1'b0, 4'h0, 5'd8, rs_low(5'd0));
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_full got=%b exp=0", in_ready); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_out_valid got=%b exp=0", out_valid); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rf_illegal got=%b exp=0", illegal); end
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_insn  = mk(OPECODE_XOR, 1'b0, 4'h0, 5'd12, rs_low(5'd0));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (data_rd !== 32'h0000_0C0C || opecode !== OPECODE_XOR) begin bad++; $display("FAIL rf_first got=%h/%h exp=00000c0c/%h", data_rd, opecode, OPECODE_XOR); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_no_stale got=%b exp=0", out_valid); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_insn   = '0;
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    test_reset();
    test_add();
    test_imm();
    test_bypass();
    test_back_to_back();
    test_illegal();
    test_reset_full();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
